soc_fifo_drain_master: RTL and testbench



---
 rtl/soc_fifo_drain_pkg.sv | 15 +
 rtl/soc_fifo_drain_outreg.sv | 37 +++
 rtl/soc_fifo_drain_master.sv | 119 +++++++++++
 tb/tb_soc_fifo_drain_master.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_fifo_drain_pkg.sv
// Shared state encoding and constants for the SoC FIFO drain master.
package soc_fifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    READ,
    GAP
  } state_t;

  localparam logic [2:0] FILL_LEVEL_ADDR = 3'd0;
  localparam int         DEFAULT_DATA_W  = 32;

endpackage

// File: rtl/soc_fifo_drain_outreg.sv
// Single-entry valid/ready output register feeding the downstream stream.
module soc_fifo_drain_outreg
  import soc_fifo_drain_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_space
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // A load wins over a same-edge drain, so a simultaneous accept keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_space = !r_valid || i_ready;

endmodule

// File: rtl/soc_fifo_drain_master.sv
// Avalon-MM master that polls the FIFO fill level and drains up to MAX_BURST
// words per poll onto a valid/ready stream.
module soc_fifo_drain_master
  import soc_fifo_drain_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 8,
  parameter int POLL_GAP  = 16
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic              enable,
  output logic [2:0]        csr_address,
  output logic              csr_read,
  input  logic [31:0]       csr_readdata,
  input  logic              fifo_irq,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] fifo_readdata,
  input  logic              fifo_waitrequest,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [31:0]       words_drained
);

  localparam int                  CREDIT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_BURST);
  localparam logic [15:0]         GAP_LAST   = 16'(POLL_GAP - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_poll;
  logic [CREDIT_W-1:0] w_credit_after;
  logic                r_pending;
  logic [15:0]         r_gap_cnt;
  logic [31:0]         r_words;
  logic                w_space;
  logic                w_read_req;
  logic                w_accept;
  logic                w_last;

  // Any fill above MAX_BURST, including values with bit 31 set, saturates.
  assign w_credit_poll = (csr_readdata > 32'(MAX_BURST)) ? CREDIT_MAX
                                                         : csr_readdata[CREDIT_W-1:0];

  // A pending read is held unconditionally; new reads need credit, enable and space.
  assign w_read_req     = (r_state == READ) &&
                          (r_pending || (enable && (r_credit != '0) && w_space));
  assign w_accept       = w_read_req && !fifo_waitrequest;
  assign w_credit_after = w_accept ? (r_credit - CREDIT_W'(1)) : r_credit;
  assign w_last         = (w_credit_after == '0);

  always_comb begin
    w_state_next = r_state;
    csr_read     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_next = POLL_REQ;
      end
      POLL_REQ: begin
        csr_read     = 1'b1;
        w_state_next = POLL_WAIT;
      end
      POLL_WAIT: begin
        w_state_next = (w_credit_poll == '0) ? GAP : READ;
      end
      READ: begin
        if (w_read_req && fifo_waitrequest) w_state_next = READ;
        else if (!enable)                   w_state_next = IDLE;
        else if (w_last)                    w_state_next = POLL_REQ;
      end
      GAP: begin
        if (!enable)                                w_state_next = IDLE;
        else if (fifo_irq || r_gap_cnt == GAP_LAST) w_state_next = POLL_REQ;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge wrclock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_credit  <= '0;
      r_pending <= 1'b0;
      r_gap_cnt <= '0;
      r_words   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_read_req && fifo_waitrequest;
      if (w_accept) r_words <= r_words + 32'd1;
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                r_gap_cnt <= '0;
      // Leaving READ for any reason discards whatever credit is left.
      if (r_state == POLL_WAIT)  r_credit <= w_credit_poll;
      else if (r_state == READ)  r_credit <= (w_state_next == READ) ? w_credit_after : '0;
    end
  end

  soc_fifo_drain_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk     (wrclock),
    .reset   (reset),
    .i_load  (w_accept),
    .i_data  (fifo_readdata),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_space (w_space)
  );

  assign csr_address   = FILL_LEVEL_ADDR;
  assign fifo_read     = w_read_req;
  assign busy          = (r_state != IDLE);
  assign words_drained = r_words;

endmodule

// File: tb/tb_soc_fifo_drain_master.sv
// Directed bench for soc_fifo_drain_master against a small FIFO slave model.
module tb_soc_fifo_drain_master;

  logic        wrclock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata = 32'hDEAD_BEEF;
  logic        fifo_irq;
  logic        fifo_read;
  logic [31:0] fifo_readdata;
  logic        fifo_waitrequest;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [31:0] words_drained;

  int          loaded = 0;
  int          rdPtr = 0;
  logic        csrPending = 1'b0;
  logic        useOverride;
  logic [31:0] overrideVal;
  int          burstAcc = 0;
  int          bursts[$];
  logic [31:0] received[$];
  int          passCount;
  int          checkCount;

  always #5 wrclock = ~wrclock;

  soc_fifo_drain_master #(
    .DATA_W    (32),
    .MAX_BURST (8),
    .POLL_GAP  (16)
  ) dut (
    .wrclock          (wrclock),
    .reset            (reset),
    .enable           (enable),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_readdata     (csr_readdata),
    .fifo_irq         (fifo_irq),
    .fifo_read        (fifo_read),
    .fifo_readdata    (fifo_readdata),
    .fifo_waitrequest (fifo_waitrequest),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .busy             (busy),
    .words_drained    (words_drained)
  );

  function automatic logic [31:0] wordAt(input int idx);
    return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0003);
  endfunction

  assign fifo_readdata = wordAt(rdPtr);

  // FIFO slave model: fill level answered one cycle after csr_read, garbage otherwise.
  always @(posedge wrclock) begin
    csrPending <= csr_read;
    if (fifo_read && !fifo_waitrequest) rdPtr <= rdPtr + 1;
  end

  always @(negedge wrclock) begin
    csr_readdata = csrPending ? (useOverride ? overrideVal : 32'(loaded - rdPtr))
                              : 32'hDEAD_BEEF;
  end

  // Monitor: words accepted between polls, and every word taken off the stream.
  always @(posedge wrclock) begin
    if (csr_read && burstAcc > 0) begin
      bursts.push_back(burstAcc);
      burstAcc = 0;
    end
    if (fifo_read && !fifo_waitrequest) burstAcc = burstAcc + 1;
    if (out_valid && out_ready) received.push_back(out_data);
  end

  task automatic applyStimulus(input logic en, input logic rdy, input logic wr, input logic irq);
    enable           = en;
    out_ready        = rdy;
    fifo_waitrequest = wr;
    fifo_irq         = irq;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic int streamErrors(input int first, input int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= received.size()) errs++;
      else if (received[first + i] !== wordAt(first + i)) errs++;
    end
    return errs;
  endfunction

  task automatic waitPoll(input string tag);
    int n = 0;
    while (csr_read !== 1'b1 && n < 200) begin
      @(negedge wrclock);
      n++;
    end
    checkOutput(tag, 32'(csr_read), 32'd1);
  endtask

  initial begin
    int gapLen;
    int burstBase;
    int n;
    passCount   = 0;
    checkCount  = 0;
    useOverride = 1'b0;
    overrideVal = 32'd0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge wrclock);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset csr_read", 32'(csr_read), 32'd0);
    checkOutput("reset fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset words", words_drained, 32'd0);
    checkOutput("csr_address", 32'(csr_address), 32'd0);

    $display("[TB] fill=3 burst");
    reset  = 1'b0;
    loaded = 3;
    @(negedge wrclock);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge wrclock);
    checkOutput("poll csr_read", 32'(csr_read), 32'd1);
    checkOutput("poll busy", 32'(busy), 32'd1);
    @(negedge wrclock);
    checkOutput("poll_wait csr_read", 32'(csr_read), 32'd0);
    checkOutput("poll_wait fifo_read", 32'(fifo_read), 32'd0);
    @(negedge wrclock);
    checkOutput("first read", 32'(fifo_read), 32'd1);
    @(negedge wrclock);
    checkOutput("word0", out_data, wordAt(0));
    checkOutput("word0 valid", 32'(out_valid), 32'd1);
    @(negedge wrclock);
    checkOutput("word1", out_data, wordAt(1));
    @(negedge wrclock);
    checkOutput("repoll csr_read", 32'(csr_read), 32'd1);
    checkOutput("word2", out_data, wordAt(2));
    checkOutput("words after 3", words_drained, 32'd3);
    repeat (2) @(negedge wrclock);
    checkOutput("gap fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("gap busy", 32'(busy), 32'd1);
    checkOutput("stream A", 32'(streamErrors(0, 3)), 32'd0);

    $display("[TB] poll gap and irq wake");
    gapLen = 0;
    while (csr_read !== 1'b1 && gapLen < 100) begin
      gapLen++;
      @(negedge wrclock);
    end
    checkOutput("gap length", 32'(gapLen), 32'd16);
    repeat (6) @(negedge wrclock);
    checkOutput("gap5 no poll", 32'(csr_read), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge wrclock);
    checkOutput("irq wake", 32'(csr_read), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] fill=20 bursts");
    burstBase = bursts.size();
    loaded    = loaded + 20;
    n = 0;
    while (bursts.size() < burstBase + 3 && n < 300) begin
      @(negedge wrclock);
      n++;
    end
    checkOutput("burst count", 32'(bursts.size() - burstBase), 32'd3);
    checkOutput("burst 1", 32'(bursts[burstBase]), 32'd8);
    checkOutput("burst 2", 32'(bursts[burstBase + 1]), 32'd8);
    checkOutput("burst 3", 32'(bursts[burstBase + 2]), 32'd4);
    checkOutput("words after 23", words_drained, 32'd23);
    checkOutput("stream 20", 32'(streamErrors(3, 20)), 32'd0);
    repeat (3) @(negedge wrclock);
    checkOutput("no overread", 32'(rdPtr), 32'd23);

    $display("[TB] waitrequest on 2nd read");
    waitPoll("poll B");
    loaded = loaded + 3;
    repeat (2) @(negedge wrclock);
    checkOutput("B read1", 32'(fifo_read), 32'd1);
    @(negedge wrclock);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("wait hold", 32'(fifo_read), 32'd1);
      checkOutput("wait no capture", words_drained, 32'd24);
      @(negedge wrclock);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("release read", 32'(fifo_read), 32'd1);
    checkOutput("release words", words_drained, 32'd24);
    @(negedge wrclock);
    checkOutput("B word1", out_data, wordAt(24));
    checkOutput("B words 25", words_drained, 32'd25);
    @(negedge wrclock);
    checkOutput("B word2", out_data, wordAt(25));
    checkOutput("B words 26", words_drained, 32'd26);
    @(negedge wrclock);
    checkOutput("stream B", 32'(streamErrors(23, 3)), 32'd0);
    checkOutput("stream B size", 32'(received.size()), 32'd26);

    $display("[TB] backpressure");
    waitPoll("poll C");
    loaded = loaded + 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge wrclock);
    checkOutput("C read1", 32'(fifo_read), 32'd1);
    @(negedge wrclock);
    checkOutput("stall no read", 32'(fifo_read), 32'd0);
    checkOutput("stall data", out_data, wordAt(26));
    for (int i = 0; i < 2; i++) begin
      @(negedge wrclock);
      checkOutput("stall hold read", 32'(fifo_read), 32'd0);
      checkOutput("stall hold data", out_data, wordAt(26));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("resume read", 32'(fifo_read), 32'd1);
    @(negedge wrclock);
    checkOutput("resume data", out_data, wordAt(27));
    checkOutput("resume valid", 32'(out_valid), 32'd1);
    @(negedge wrclock);
    @(negedge wrclock);
    checkOutput("C words 29", words_drained, 32'd29);
    @(negedge wrclock);

    $display("[TB] enable dropped mid-burst");
    waitPoll("poll D");
    loaded = loaded + 6;
    repeat (2) @(negedge wrclock);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge wrclock);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("disable pending read", 32'(fifo_read), 32'd1);
    @(negedge wrclock);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge wrclock);
    checkOutput("disable idle busy", 32'(busy), 32'd0);
    checkOutput("disable no read", 32'(fifo_read), 32'd0);
    checkOutput("disable words", words_drained, 32'd30);
    checkOutput("disable data", out_data, wordAt(29));
    repeat (3) @(negedge wrclock);
    checkOutput("disable rdptr", 32'(rdPtr), 32'd30);

    $display("[TB] reset during pending read");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge wrclock);
    checkOutput("E poll", 32'(csr_read), 32'd1);
    repeat (2) @(negedge wrclock);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge wrclock);
    checkOutput("E pending", 32'(fifo_read), 32'd1);
    reset = 1'b1;
    @(negedge wrclock);
    checkOutput("rst fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("rst csr_read", 32'(csr_read), 32'd0);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_data", out_data, 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst words", words_drained, 32'd0);
    checkOutput("rst rdptr", 32'(rdPtr), 32'd30);

    $display("[TB] fill saturation");
    reset       = 1'b0;
    useOverride = 1'b1;
    overrideVal = 32'h8000_0003;
    burstBase   = bursts.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (bursts.size() <= burstBase && n < 100) begin
      @(negedge wrclock);
      n++;
    end
    checkOutput("sat burst", 32'(bursts[burstBase]), 32'd8);
    checkOutput("sat words", words_drained, 32'd8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge wrclock);
      n++;
    end
    checkOutput("sat idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
